// File: rtl/instruction_memory_ctrl_pkg.sv
// rtl/instruction_memory_ctrl_pkg.sv - shared types and address checking for the instruction memory
package imem_pkg;

  typedef enum logic {CLEAR, RUN} state_e;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;

  typedef struct packed {
    logic [63:0] index;
    logic [1:0]  err;
  } addr_chk_t;

  // Range is judged on the full-width word index so high address bits can never alias low words.
  function automatic addr_chk_t check_addr(input logic [63:0] addr, input int byte_log2,
                                           input logic [63:0] depth);
    addr_chk_t   r;
    logic [63:0] mask;
    mask    = (64'd1 << byte_log2) - 64'd1;
    r.index = addr >> byte_log2;
    if (r.index >= depth)
      r.err = ERR_RANGE;
    else if ((addr & mask) != 64'd0)
      r.err = ERR_MISALIGN;
    else
      r.err = ERR_OK;
    return r;
  endfunction

endpackage

// File: rtl/instruction_memory_ctrl_if.sv
// rtl/instruction_memory_ctrl_if.sv - fetch, response and program-load signals of the instruction memory
interface instruction_memory_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  busy;
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic [1:0]            rsp_err;
  logic                  load_en;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_err;

  modport master (
    input  busy, req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err, load_err,
    output req_valid, req_addr, rsp_ready, load_en, load_addr, load_data
  );

  modport slave (
    output busy, req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err, load_err,
    input  req_valid, req_addr, rsp_ready, load_en, load_addr, load_data
  );
endinterface

// File: rtl/instruction_memory_ctrl_array.sv
// rtl/instruction_memory_ctrl_array.sv - 1W/1R synchronous storage, a read colliding with a write returns old data
module imem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 128,
  parameter int IDX_W      = 7
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (re)
      rdata <= mem[raddr];
  end
endmodule

// File: rtl/instruction_memory_ctrl.sv
// rtl/instruction_memory_ctrl.sv - instruction memory with clear sequencer, valid/ready fetch and program load
module instruction_memory_ctrl
  import imem_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 128,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
  input logic                       clk,
  input logic                       reset,
  instruction_memory_ctrl_if.slave  bus
);
  localparam int               BYTES_LOG2 = $clog2(DATA_WIDTH / 8);
  localparam int               IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DEPTH - 1);

  state_e                state, state_next;
  logic [IDX_W-1:0]      clr_idx;
  addr_chk_t             req_chk, load_chk;
  logic [IDX_W-1:0]      req_idx, load_idx, waddr;
  logic [DATA_WIDTH-1:0] wdata, rd_data;
  logic                  we, ready, busy, load_rej, accept;
  logic                  rsp_valid, load_err;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic [1:0]            rsp_err;

  assign req_chk  = check_addr(64'(bus.req_addr), BYTES_LOG2, 64'(DEPTH));
  assign load_chk = check_addr(64'(bus.load_addr), BYTES_LOG2, 64'(DEPTH));
  assign req_idx  = IDX_W'(req_chk.index);
  assign load_idx = IDX_W'(load_chk.index);
  assign accept   = bus.req_valid && ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR)
        clr_idx <= clr_idx + IDX_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    ready      = 1'b0;
    we         = 1'b0;
    waddr      = clr_idx;
    wdata      = FILL_VALUE;
    load_rej   = 1'b0;
    unique case (state)
      CLEAR: begin
        busy = 1'b1;
        we   = 1'b1;
        if (clr_idx == LAST_IDX)
          state_next = RUN;
      end
      RUN: begin
        ready = !rsp_valid || bus.rsp_ready;
        if (bus.load_en) begin
          if (load_chk.err == ERR_OK) begin
            we    = 1'b1;
            waddr = load_idx;
            wdata = bus.load_data;
          end else begin
            load_rej = 1'b1;
          end
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_err   <= ERR_OK;
      load_err  <= 1'b0;
    end else begin
      load_err <= load_rej;
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_addr  <= bus.req_addr;
        rsp_err   <= req_chk.err;
      end else if (bus.rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  imem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (accept),
    .raddr (req_idx),
    .rdata (rd_data)
  );

  // The array read register has no reset; rsp_valid masks it so reset reads back zero.
  assign bus.rsp_data  = !rsp_valid ? '0 : ((rsp_err == ERR_OK) ? rd_data : FILL_VALUE);
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_addr  = rsp_addr;
  assign bus.rsp_err   = rsp_err;
  assign bus.req_ready = ready;
  assign bus.busy      = busy;
  assign bus.load_err  = load_err;
endmodule
